// File: rtl/melody_pkg.sv
// Shared types, widths and pitch table for the melody sequencer.
package melody_pkg;

    localparam int unsigned PERIOD_W  = 12;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned TEMPO_W   = 16;
    localparam int unsigned CODE_W    = 4;
    localparam int unsigned ENTRY_W   = 8;
    localparam int unsigned NUM_PITCH = 14;

    localparam logic [CODE_W-1:0] PITCH_REST = 4'd0;
    localparam logic [CODE_W-1:0] PITCH_END  = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_PRESENT = 3'd2,
        ST_HOLD    = 3'd3,
        ST_END     = 3'd4
    } state_e;

    // One melody ROM word: pitch code in the upper nibble, duration code below.
    typedef struct packed {
        logic [CODE_W-1:0] pitch;
        logic [CODE_W-1:0] dur;
    } entry_t;

    // Half-period counts at a 1 MHz tone clock, pitch codes 1..14 (C4..B5, D major).
    localparam logic [PERIOD_W-1:0] PERIOD_TABLE [NUM_PITCH] = '{
        12'd1908, 12'd1703, 12'd1517, 12'd1351, 12'd1276, 12'd1136, 12'd1012,
        12'd902,  12'd851,  12'd758,  12'd675,  12'd638,  12'd568,  12'd506
    };

    // Rest and end marker both map to silence.
    function automatic logic [PERIOD_W-1:0] pitch_to_period(input logic [CODE_W-1:0] code);
        logic [PERIOD_W-1:0] period;
        period = '0;
        if ((code != PITCH_REST) && (code != PITCH_END)) begin
            period = PERIOD_TABLE[CODE_W'(code - CODE_W'(1))];
        end
        return period;
    endfunction

endpackage

// File: rtl/melody_if.sv
// Control and note-stream signals between the sequencer and its tone stage.
interface melody_if;
    import melody_pkg::*;

    logic                start;
    logic                stop;
    logic [TEMPO_W-1:0]  tempo_div;
    logic                note_ready;
    logic [PERIOD_W-1:0] note_period;
    logic                note_valid;
    logic                playing;
    logic [IDX_W-1:0]    note_index;
    logic                done;

    modport master (
        input  start, stop, tempo_div, note_ready,
        output note_period, note_valid, playing, note_index, done
    );

    modport slave (
        output start, stop, tempo_div, note_ready,
        input  note_period, note_valid, playing, note_index, done
    );

endinterface

// File: rtl/melody_rom.sv
// Synchronous 64x8 melody table; SONG selects the Canon tune or a short test tune.
module melody_rom
    import melody_pkg::*;
#(
    parameter int unsigned SONG = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] addr,
    output entry_t           rd_data
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    // Canon-style progression in D, eight bars of eight entries, no end marker.
    localparam logic [ENTRY_W-1:0] CANON [DEPTH] = '{
        8'h31, 8'h90, 8'h61, 8'h70, 8'h41, 8'h50, 8'h21, 8'h02,
        8'h51, 8'h20, 8'h51, 8'h60, 8'hB1, 8'hD0, 8'hE1, 8'hB0,
        8'hC1, 8'hA0, 8'hB1, 8'h90, 8'hA1, 8'h80, 8'h91, 8'h60,
        8'h73, 8'h60, 8'h53, 8'h40, 8'h33, 8'h20, 8'h13, 8'h02,
        8'h92, 8'h60, 8'h72, 8'h40, 8'h52, 8'h90, 8'h51, 8'h60,
        8'h21, 8'h61, 8'h71, 8'h41, 8'h51, 8'h21, 8'h51, 8'h61,
        8'hB1, 8'hD1, 8'hE1, 8'hB1, 8'hC1, 8'hA1, 8'hB1, 8'h91,
        8'h81, 8'h91, 8'hA1, 8'h81, 8'h93, 8'h00, 8'h92, 8'h03
    };

    // Two notes followed by the end marker.
    localparam logic [ENTRY_W-1:0] SHORT [DEPTH] = '{
        0: 8'h31, 1: 8'h50, 2: 8'hF0, default: 8'h00
    };

    logic [ENTRY_W-1:0] data_d;
    logic [ENTRY_W-1:0] data_q;

    // Table lookup for the addressed entry.
    always_comb begin
        data_d = CANON[addr];
        if (SONG == 32'd1) begin
            data_d = SHORT[addr];
        end
    end

    // Registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign rd_data = entry_t'(data_q);

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the melody ROM, presents each note over valid/ready and holds it for its duration.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int unsigned LOOP      = 0,
    parameter int unsigned ROM_DEPTH = 64,
    parameter int unsigned SONG      = 0
) (
    input  logic     clk,
    input  logic     rst,
    melody_if.master bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROM_DEPTH - 1);

    state_e              state_q,       state_d;
    logic [IDX_W-1:0]    note_index_q,  note_index_d;
    logic [PERIOD_W-1:0] note_period_q, note_period_d;
    logic                note_valid_q,  note_valid_d;
    logic                done_q,        done_d;
    logic                playing_q,     playing_d;
    logic                fetch_rdy_q,   fetch_rdy_d;
    logic [TEMPO_W-1:0]  tick_q,        tick_d;
    logic [TEMPO_W-1:0]  tempo_m1_q,    tempo_m1_d;
    logic [CODE_W-1:0]   dur_q,         dur_d;

    entry_t rom_data;

    melody_rom #(
        .SONG (SONG)
    ) u_rom (
        .clk     (clk),
        .rst     (rst),
        .addr    (note_index_q),
        .rd_data (rom_data)
    );

    // Next-state, counter and output decode; stop pre-empts every non-idle state.
    always_comb begin
        state_d       = state_q;
        note_index_d  = note_index_q;
        note_period_d = note_period_q;
        note_valid_d  = note_valid_q;
        done_d        = 1'b0;
        fetch_rdy_d   = fetch_rdy_q;
        tick_d        = tick_q;
        tempo_m1_d    = tempo_m1_q;
        dur_d         = dur_q;

        if ((state_q != ST_IDLE) && bus.stop) begin
            state_d       = ST_IDLE;
            note_valid_d  = 1'b0;
            note_period_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_d      = ST_FETCH;
                        note_index_d = '0;
                        fetch_rdy_d  = 1'b0;
                    end
                end
                ST_FETCH: begin
                    // First cycle issues the read, second cycle consumes the registered data.
                    if (!fetch_rdy_q) begin
                        fetch_rdy_d = 1'b1;
                    end else if (rom_data.pitch == PITCH_END) begin
                        state_d = ST_END;
                    end else begin
                        state_d       = ST_PRESENT;
                        note_period_d = pitch_to_period(rom_data.pitch);
                        note_valid_d  = 1'b1;
                        dur_d         = rom_data.dur;
                    end
                end
                ST_PRESENT: begin
                    if (bus.note_ready) begin
                        state_d      = ST_HOLD;
                        note_valid_d = 1'b0;
                        tick_d       = '0;
                        tempo_m1_d   = (bus.tempo_div == '0) ? '0
                                                             : TEMPO_W'(bus.tempo_div - TEMPO_W'(1));
                    end
                end
                ST_HOLD: begin
                    if (tick_q == tempo_m1_q) begin
                        tick_d = '0;
                        if (dur_q == '0) begin
                            if (note_index_q == LAST_IDX) begin
                                state_d = ST_END;
                            end else begin
                                state_d      = ST_FETCH;
                                note_index_d = IDX_W'(note_index_q + IDX_W'(1));
                                fetch_rdy_d  = 1'b0;
                            end
                        end else begin
                            dur_d = CODE_W'(dur_q - CODE_W'(1));
                        end
                    end else begin
                        tick_d = TEMPO_W'(tick_q + TEMPO_W'(1));
                    end
                end
                ST_END: begin
                    if (LOOP != 0) begin
                        state_d      = ST_FETCH;
                        note_index_d = '0;
                        fetch_rdy_d  = 1'b0;
                    end else begin
                        state_d       = ST_IDLE;
                        done_d        = 1'b1;
                        note_period_d = '0;
                    end
                end
                default: begin
                    state_d       = ST_IDLE;
                    note_valid_d  = 1'b0;
                    note_period_d = '0;
                end
            endcase
        end

        playing_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            note_index_q  <= '0;
            note_period_q <= '0;
            note_valid_q  <= 1'b0;
            done_q        <= 1'b0;
            playing_q     <= 1'b0;
            fetch_rdy_q   <= 1'b0;
            tick_q        <= '0;
            tempo_m1_q    <= '0;
            dur_q         <= '0;
        end else begin
            state_q       <= state_d;
            note_index_q  <= note_index_d;
            note_period_q <= note_period_d;
            note_valid_q  <= note_valid_d;
            done_q        <= done_d;
            playing_q     <= playing_d;
            fetch_rdy_q   <= fetch_rdy_d;
            tick_q        <= tick_d;
            tempo_m1_q    <= tempo_m1_d;
            dur_q         <= dur_d;
        end
    end

    assign bus.note_period = note_period_q;
    assign bus.note_valid  = note_valid_q;
    assign bus.playing     = playing_q;
    assign bus.note_index  = note_index_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench: three sequencer builds (Canon/stop, short/stop, short/loop) sharing one driver.
module tb_melody_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_r = 1'b0;
    logic       stop_r = 1'b0;
    logic       ready_r = 1'b0;
    logic [15:0] tempo_r = 16'd4;
    int         sel = 0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    melody_if bus0 ();
    melody_if bus1 ();
    melody_if bus2 ();

    assign bus0.start = start_r && (sel == 0);
    assign bus1.start = start_r && (sel == 1);
    assign bus2.start = start_r && (sel == 2);
    assign bus0.stop = stop_r;
    assign bus1.stop = stop_r;
    assign bus2.stop = stop_r;
    assign bus0.tempo_div = tempo_r;
    assign bus1.tempo_div = tempo_r;
    assign bus2.tempo_div = tempo_r;
    assign bus0.note_ready = ready_r;
    assign bus1.note_ready = ready_r;
    assign bus2.note_ready = ready_r;

    melody_sequencer #(.LOOP(0), .ROM_DEPTH(64), .SONG(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    melody_sequencer #(.LOOP(0), .ROM_DEPTH(64), .SONG(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    melody_sequencer #(.LOOP(1), .ROM_DEPTH(64), .SONG(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic        m_valid, m_playing, m_done;
    logic [11:0] m_period;
    logic [5:0]  m_index;

    always_comb begin
        m_valid = bus0.note_valid; m_playing = bus0.playing; m_done = bus0.done;
        m_period = bus0.note_period; m_index = bus0.note_index;
        if (sel == 1) begin
            m_valid = bus1.note_valid; m_playing = bus1.playing; m_done = bus1.done;
            m_period = bus1.note_period; m_index = bus1.note_index;
        end else if (sel == 2) begin
            m_valid = bus2.note_valid; m_playing = bus2.playing; m_done = bus2.done;
            m_period = bus2.note_period; m_index = bus2.note_index;
        end
    end

    // Hand-entered expectations: pitch-code half-periods and the Canon table bytes.
    localparam int PER [16] = '{0, 1908, 1703, 1517, 1351, 1276, 1136, 1012,
                                902, 851, 758, 675, 638, 568, 506, 0};
    localparam int CANON_B [64] = '{
        'h31, 'h90, 'h61, 'h70, 'h41, 'h50, 'h21, 'h02,
        'h51, 'h20, 'h51, 'h60, 'hB1, 'hD0, 'hE1, 'hB0,
        'hC1, 'hA0, 'hB1, 'h90, 'hA1, 'h80, 'h91, 'h60,
        'h73, 'h60, 'h53, 'h40, 'h33, 'h20, 'h13, 'h02,
        'h92, 'h60, 'h72, 'h40, 'h52, 'h90, 'h51, 'h60,
        'h21, 'h61, 'h71, 'h41, 'h51, 'h21, 'h51, 'h61,
        'hB1, 'hD1, 'hE1, 'hB1, 'hC1, 'hA1, 'hB1, 'h91,
        'h81, 'h91, 'hA1, 'h81, 'h93, 'h00, 'h92, 'h03
    };

    typedef struct {
        int idx;
        int period;
        int gap;
    } exp_t;

    exp_t exp_q[$];

    task automatic cmp(input string name, input int act, input int expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push_note(input int idx, input int period, input int gap);
        exp_t e;
        e.idx = idx; e.period = period; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Monitor state
    int   last_ref = 0;
    int   done_cnt = 0;
    int   done_gap = -1;
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_stop = 1'b0, prev_done = 1'b0;
    int   prev_period = 0, prev_index = 0;
    exp_t got;

    // Monitor: pops the scoreboard on each new note, checks stability under backpressure.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0; prev_ready = 1'b0; prev_stop = 1'b0; prev_done = 1'b0;
        end else begin
            if (m_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_note: got index %0d period %0d expected none (t=%0t)",
                             m_index, m_period, $time);
                end else begin
                    got = exp_q.pop_front();
                    cmp("note_index", int'(m_index), got.idx);
                    cmp("note_period", int'(m_period), got.period);
                    if (got.gap != 0) cmp("valid_latency", cyc - last_ref, got.gap);
                end
            end
            if (prev_valid && !prev_ready && !prev_stop) begin
                cmp("stall_valid", int'(m_valid), 1);
                cmp("stall_period", int'(m_period), prev_period);
                cmp("stall_index", int'(m_index), prev_index);
            end
            if (m_done && !prev_done) done_gap = cyc - last_ref;
            if (m_done) done_cnt++;
            if (start_r && !stop_r && !m_playing) last_ref = cyc + 1;
            if (m_valid && ready_r) last_ref = cyc + 1;
            prev_valid = m_valid; prev_ready = ready_r; prev_stop = stop_r; prev_done = m_done;
            prev_period = int'(m_period); prev_index = int'(m_index);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
    endtask

    task automatic wait_q(input int left, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() > left && n < max_cyc) begin
            tick();
            n++;
        end
        if (exp_q.size() > left) begin
            cmp("note_timeout", exp_q.size(), left);
            exp_q.delete();
        end
    endtask

    task automatic wait_done(input int base, input int max_cyc);
        int n;
        n = 0;
        while (done_cnt <= base && n < max_cyc) begin
            tick();
            n++;
        end
        if (done_cnt <= base) cmp("done_timeout", done_cnt, base + 1);
    endtask

    task automatic check_idle(input string tag);
        cmp({tag, "_valid"}, int'(m_valid), 0);
        cmp({tag, "_period"}, int'(m_period), 0);
        cmp({tag, "_playing"}, int'(m_playing), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int gap;

        // Reset state
        tick();
        check_idle("reset");
        cmp("reset_index", int'(m_index), 0);
        cmp("reset_done", int'(m_done), 0);
        rst = 1'b0;
        repeat (3) tick();
        cmp("idle_after_reset", int'(m_playing), 0);

        // Basic timing: tempo 4, ready high
        sel = 0; tempo_r = 16'd4; ready_r = 1'b1;
        push_note(0, 1517, 2);
        push_note(1, 851, 10);
        push_note(2, 1136, 6);
        pulse_start();
        wait_q(0, 100);

        // Asynchronous reset in the middle of a held note, then replay from index 0
        repeat (2) tick();
        cmp("pre_reset_playing", int'(m_playing), 1);
        #1 rst = 1'b1;
        #1;
        check_idle("async_reset");
        cmp("async_reset_index", int'(m_index), 0);
        cmp("async_reset_done", int'(m_done), 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        cmp("stay_idle", int'(m_playing), 0);

        // Backpressure: ready low 20 cycles, then one handshake, then stop while presenting
        ready_r = 1'b0;
        push_note(0, 1517, 2);
        push_note(1, 851, 10);
        pulse_start();
        wait_q(1, 20);
        repeat (20) tick();
        ready_r = 1'b1;
        tick();
        ready_r = 1'b0;
        wait_q(0, 40);
        cmp("present_valid", int'(m_valid), 1);
        base = done_cnt;
        stop_r = 1'b1;
        tick();
        stop_r = 1'b0;
        check_idle("stop_present");
        cmp("stop_no_done", done_cnt, base);

        // start and stop together: stays idle
        start_r = 1'b1; stop_r = 1'b1;
        tick();
        start_r = 1'b0; stop_r = 1'b0;
        repeat (3) tick();
        check_idle("start_stop");

        // End marker without loop, tempo 0
        sel = 1; tempo_r = 16'd0; ready_r = 1'b1;
        base = done_cnt;
        push_note(0, 1517, 2);
        push_note(1, 1276, 4);
        pulse_start();
        wait_q(0, 40);
        wait_done(base, 40);
        cmp("end_done_gap", done_gap, 4);
        check_idle("end_noloop");
        repeat (3) tick();
        cmp("end_done_count", done_cnt, base + 1);

        // End marker with loop
        sel = 2;
        base = done_cnt;
        push_note(0, 1517, 2);
        push_note(1, 1276, 4);
        push_note(0, 1517, 6);
        push_note(1, 1276, 4);
        pulse_start();
        wait_q(0, 60);
        cmp("loop_playing", int'(m_playing), 1);
        stop_r = 1'b1;
        tick();
        stop_r = 1'b0;
        check_idle("loop_stop");
        cmp("loop_no_done", done_cnt, base);

        // Full 64-entry wrap, tempo 0, with an ignored restart in the middle
        sel = 0;
        base = done_cnt;
        for (int i = 0; i < 64; i++) begin
            gap = (i == 0) ? 2 : ((CANON_B[i-1] & 'hF) + 3);
            push_note(i, PER[CANON_B[i] >> 4], gap);
        end
        pulse_start();
        wait_q(40, 200);
        pulse_start();
        wait_q(0, 600);
        wait_done(base, 40);
        cmp("wrap_done_gap", done_gap, 5);
        cmp("wrap_index", int'(m_index), 63);
        check_idle("wrap_end");
        repeat (3) tick();
        cmp("wrap_done_count", done_cnt, base + 1);

        cmp("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 The block SHALL have parameter LOOP, default 0: 1 means restart at index 0 after the end marker; 0 means stop there.
REQ-002 The block SHALL have parameter ROM_DEPTH, default 64: number of melody entries; index width is 6.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  level sampled each edge; begins playback from index 0 when IDLE.
REQ-006 stop  in  1  level sampled each edge; aborts playback.
REQ-007 tempo_div  in  16  clk cycles per tick; 1 tick = 1/16 beat.
REQ-008 note_ready  in  1  downstream PWM tone stage accepts note_period.
REQ-009 note_period  out  12  half-period count for the tone generator; 0 = rest (silence).
REQ-010 note_valid  out  1  note_period holds a new note awaiting acceptance.
REQ-011 playing  out  1  high in any state other than IDLE.
REQ-012 note_index  out  6  index of the entry currently presented or held.
REQ-013 done  out  1  one-cycle pulse when playback ends without looping.

Function
REQ-014 ROM entry is 8 bits: [7:4] pitch code, [3:0] duration code d; note length = (d+1) ticks (1..16 ticks).
REQ-015 Pitch code 0 SHALL map to note_period 0 (rest), codes 1..14 to the package period table, and code 15 to the end marker.
REQ-016 The FSM SHALL have states IDLE, FETCH, PRESENT, HOLD and END.
REQ-017 IDLE->FETCH on start=1 and stop=0; note_index is cleared to 0.
REQ-018 FETCH reads the ROM (registered, 1-cycle read) and moves to PRESENT, or to END if the pitch code is 15.
REQ-019 On entering PRESENT, note_period SHALL be loaded and note_valid SHALL be set.
REQ-020 In PRESENT, note_valid and note_period SHALL stay stable until the edge where note_ready=1; that edge clears note_valid and enters HOLD.
REQ-021 HOLD SHALL last exactly (d+1)*max(tempo_div,1) cycles; tempo_div=0 is treated as 1; tempo_div is sampled on entry to HOLD.
REQ-022 At HOLD end: if note_index=ROM_DEPTH-1, go to END; otherwise increment note_index and go to FETCH.
REQ-023 END with LOOP=1: clear note_index, go to FETCH, no done pulse.
REQ-024 END with LOOP=0: pulse done for one cycle, load note_period=0 without note_valid, and go to IDLE.
REQ-025 Latency: note_valid SHALL first be high 2 edges after the edge that samples start.
REQ-026 stop=1 in any non-IDLE state forces IDLE at the next edge: note_valid=0, note_period=0, no done pulse; this deliberately breaks the valid/ready rule.
REQ-027 start and stop both high: stop wins. start while playing is ignored.
REQ-028 note_period SHALL hold its value during HOLD (the tone keeps sounding) until the next PRESENT load or a stop/end.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, note_period=0, note_valid=0, playing=0, note_index=0, done=0, and clear the tick/duration counters, including mid-HOLD or mid-handshake.
REQ-030 After rst deasserts, the block SHALL stay IDLE until start is sampled high.

Structure
REQ-031 Package melody_pkg SHALL hold the state enum, the pitch code constants (REST=0, END=15), the 14-entry 12-bit period table, and the widths (PERIOD_W=12, IDX_W=6).
REQ-032 Sub-module melody_rom SHALL hold the synchronous 64x8 melody table (Canon progression); the sequencer SHALL contain only the FSM and the counters.

Verification
REQ-033 Reset mid-HOLD: rst pulse during a note -> all outputs 0 asynchronously, IDLE; start afterwards replays from index 0.
REQ-034 Basic timing: tempo_div=4, ROM[0]=pitch 3/d=1, ready tied high -> note_valid high 2 edges after start; next note_valid exactly 1+8+1 cycles after handshake; note_period = table[3].
REQ-035 Backpressure: hold note_ready low 20 cycles -> note_valid and note_period stable throughout; HOLD begins the edge ready rises.
REQ-036 End and loop: ROM[2]=end marker. LOOP=0 -> done pulse once, note_period=0, playing falls. LOOP=1 -> index returns to 0 with no done pulse.
REQ-037 Stop and tempo: stop during PRESENT -> IDLE next edge with note_valid=0. start+stop together -> stays IDLE. tempo_div=0 -> HOLD of d=0 lasts 1 cycle.
REQ-038 Wrap: a full 64-entry ROM with no end marker -> END after index 63; note_index never exceeds 63.
